// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD frame collector and its altsum accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGIT  = 9;
    localparam int MOD11      = 11;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } coll_state_t;

endpackage

// File: rtl/bcd_altsum_mod11.sv
// Running alternating digit sum mod 11 for an MSD-first digit stream: acc <= (digit - acc) mod 11.
// Latency: sum reflects an accepted digit one clock after en.
// Backpressure: none; en is only pulsed by the owner on an accepted digit, clr has priority.
module bcd_altsum_mod11
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  bcd_digit_t digit,
    output logic [3:0] sum
);

    logic [4:0] wide;
    logic [3:0] next_sum;

    // (digit - sum) mod 11 without a signed path: bias by 11 first, then fold once
    always_comb begin
        wide     = {1'b0, digit} + 5'(MOD11) - {1'b0, sum};
        next_sum = (wide >= 5'(MOD11)) ? 4'(wide - 5'(MOD11)) : 4'(wide);
    end

    // Accumulator register; clear beats a digit update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 4'd0;
        end else if (clr) begin
            sum <= 4'd0;
        end else if (en) begin
            sum <= next_sum;
        end
    end

endmodule

// File: rtl/bcd_frame_collector.sv
// Serial MSD-first BCD digits in, four-digit parallel frame out on a/b/c/d; optional BCD_FRAME_ALTSUM_EN adds altsum.
// Latency: frame_valid rises 1 clock after the 4th digit is accepted; 5 cycles per frame with an immediate ack.
// Backpressure: digit_ready drops while a frame is held (until frame_ack) or during clear; source must hold its digit.
module bcd_frame_collector #(
    parameter int NUM_DIGITS = bcd_pkg::NUM_DIGITS,
    parameter int DIGIT_W    = bcd_pkg::DIGIT_W,
    parameter int MAX_DIGIT  = bcd_pkg::MAX_DIGIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               digit_valid,
    output logic               digit_ready,
    output logic [DIGIT_W-1:0] a,
    output logic [DIGIT_W-1:0] b,
    output logic [DIGIT_W-1:0] c,
    output logic [DIGIT_W-1:0] d,
    output logic               frame_valid,
    input  logic               frame_ack,
    output logic               err_digit,
    output logic [2:0]         digit_cnt
`ifdef BCD_FRAME_ALTSUM_EN
    ,
    output logic [3:0]         altsum
`endif
);

    import bcd_pkg::*;

    coll_state_t state;
    logic        legal;
    logic        take;
    logic        drop;
    logic        last_slot;

    // Handshake decode: a digit is offered only while collecting and not being aborted
    always_comb begin
        digit_ready = (state == COLLECT) && !clear;
        legal       = (digit_in <= DIGIT_W'(MAX_DIGIT));
        take        = digit_valid && digit_ready && legal;
        drop        = digit_valid && digit_ready && !legal;
        last_slot   = (digit_cnt == 3'(NUM_DIGITS - 1));
    end

    // Collector FSM with registered frame slots, count and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT;
            digit_cnt   <= 3'd0;
            frame_valid <= 1'b0;
            err_digit   <= 1'b0;
            a           <= '0;
            b           <= '0;
            c           <= '0;
            d           <= '0;
        end else begin
            // drop already excludes clear and FULL through digit_ready
            err_digit <= drop;
            if (clear) begin
                state       <= COLLECT;
                digit_cnt   <= 3'd0;
                frame_valid <= 1'b0;
                a           <= '0;
                b           <= '0;
                c           <= '0;
                d           <= '0;
            end else begin
                case (state)
                    COLLECT: begin
                        if (take) begin
                            case (digit_cnt)
                                3'd0:    a <= digit_in;
                                3'd1:    b <= digit_in;
                                3'd2:    c <= digit_in;
                                3'd3:    d <= digit_in;
                                default: ;
                            endcase
                            // count stops at NUM_DIGITS because the last slot leaves COLLECT
                            digit_cnt <= digit_cnt + 3'd1;
                            if (last_slot) begin
                                state       <= FULL;
                                frame_valid <= 1'b1;
                            end
                        end
                    end
                    FULL: begin
                        // slots are left as-is; the next frame overwrites them one by one
                        if (frame_ack) begin
                            state       <= COLLECT;
                            frame_valid <= 1'b0;
                            digit_cnt   <= 3'd0;
                        end
                    end
                    default: begin
                        state <= COLLECT;
                    end
                endcase
            end
        end
    end

`ifdef BCD_FRAME_ALTSUM_EN
    logic altsum_clr;

    // Accumulator restarts on abort or when the consumer takes the frame
    always_comb begin
        altsum_clr = clear || ((state == FULL) && frame_ack);
    end

    bcd_altsum_mod11 u_altsum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (altsum_clr),
        .en    (take),
        .digit (digit_in),
        .sum   (altsum)
    );
`endif

endmodule

// File: tb/tb_bcd_frame_collector.sv
// Scoreboard bench for bcd_frame_collector: directed test-plan sequences followed by random traffic.
// Latency: frame and err_digit timing checked against cycle stamps from the reference model.
// Backpressure: digit_ready checked every cycle against the model's holding state.
module tb_bcd_frame_collector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] digit_in = 4'd0;
    logic       digit_valid = 1'b0;
    logic       digit_ready;
    logic [3:0] a, b, c, d;
    logic       frame_valid;
    logic       frame_ack = 1'b0;
    logic       err_digit;
    logic [2:0] digit_cnt;
`ifdef BCD_FRAME_ALTSUM_EN
    logic [3:0] altsum;
`endif

    bcd_frame_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .err_digit   (err_digit),
        .digit_cnt   (digit_cnt)
`ifdef BCD_FRAME_ALTSUM_EN
        ,
        .altsum      (altsum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int a;
        int b;
        int c;
        int d;
        int at;
    } frame_t;

    frame_t frame_q[$];
    int     err_q[$];
    int     errs = 0;
    int     checks = 0;

    // Reference model: digits held so far and how many of them belong to the current frame
    int     mcnt = 0;
    int     md[4] = '{0, 0, 0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errs++;
        $display("FAIL %s: got unexpected event expected none (cycle %0d)", name, cyc);
    endtask

    // One clock of stimulus; entered and left at posedge+1
    task automatic step(input logic v, input logic [3:0] dg, input logic ak, input logic cl);
        chk("digit_cnt", digit_cnt, mcnt);
        chk("frame_valid", frame_valid, mcnt == 4);
        chk("slot_a", a, md[0]);
        chk("slot_b", b, md[1]);
        chk("slot_c", c, md[2]);
        chk("slot_d", d, md[3]);
        digit_valid = v;
        digit_in    = dg;
        frame_ack   = ak;
        clear       = cl;
        #1;
        chk("digit_ready", digit_ready, (mcnt < 4) && !cl);
        if (cl) begin
            mcnt = 0;
            md   = '{0, 0, 0, 0};
        end else if (mcnt == 4) begin
            if (ak) mcnt = 0;
        end else if (v) begin
            if (dg <= 4'd9) begin
                md[mcnt] = int'(dg);
                mcnt++;
                if (mcnt == 4) frame_q.push_back('{md[0], md[1], md[2], md[3], cyc + 1});
            end else begin
                err_q.push_back(cyc + 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a new frame or an error pulse
    logic fv_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            fv_prev = 1'b0;
        end else begin
            if (frame_valid && !fv_prev) begin
                if (frame_q.size() == 0) begin
                    fail_now("frame_unexpected");
                end else begin
                    frame_t f;
                    f = frame_q.pop_front();
                    chk("frame_a", a, f.a);
                    chk("frame_b", b, f.b);
                    chk("frame_c", c, f.c);
                    chk("frame_d", d, f.d);
                    chk("frame_latency", cyc, f.at);
`ifdef BCD_FRAME_ALTSUM_EN
                    chk("altsum", altsum, (f.a * 1000 + f.b * 100 + f.c * 10 + f.d) % 11);
`endif
                end
            end
            if (err_digit) begin
                if (err_q.size() == 0) begin
                    fail_now("err_unexpected");
                end else begin
                    chk("err_cycle", cyc, err_q.pop_front());
                end
            end
            fv_prev = frame_valid;
        end
    end

    initial begin
        // Reset state while rst_n is held low
        #12;
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_c", c, 0);
        chk("rst_d", d, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_err_digit", err_digit, 0);
        chk("rst_digit_cnt", digit_cnt, 0);
        chk("rst_digit_ready", digit_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 9999 back to back, held one idle cycle, then acked
        for (int i = 0; i < 4; i++) step(1'b1, 4'd9, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);

        // 1,2,A,3,4: the illegal code is dropped with one error pulse
        step(1'b1, 4'd1, 1'b0, 1'b0);
        step(1'b1, 4'd2, 1'b0, 1'b0);
        step(1'b1, 4'd10, 1'b0, 1'b0);
        step(1'b1, 4'd3, 1'b0, 1'b0);
        step(1'b1, 4'd4, 1'b0, 1'b0);

        // Held digit 5 while FULL, then ack; 5 lands in slot a afterwards
        for (int i = 0; i < 3; i++) step(1'b1, 4'd5, 1'b0, 1'b0);
        step(1'b1, 4'd5, 1'b1, 1'b0);
        step(1'b1, 4'd5, 1'b0, 1'b0);

        // Abort, then 7,8 and clear alongside a valid 6
        step(1'b0, 4'd0, 1'b0, 1'b1);
        step(1'b1, 4'd7, 1'b0, 1'b0);
        step(1'b1, 4'd8, 1'b0, 1'b0);
        step(1'b1, 4'd6, 1'b1, 1'b1);
        step(1'b0, 4'd0, 1'b0, 1'b0);

        // Back-to-back illegal codes, ack while collecting is ignored
        step(1'b1, 4'd10, 1'b1, 1'b0);
        step(1'b1, 4'd15, 1'b0, 1'b0);

        // Full-rate frames: 3141 then 0000 with an ack on the first FULL cycle
        step(1'b1, 4'd3, 1'b0, 1'b0);
        step(1'b1, 4'd1, 1'b0, 1'b0);
        step(1'b1, 4'd4, 1'b0, 1'b0);
        step(1'b1, 4'd1, 1'b0, 1'b0);
        step(1'b1, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 4'd0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);

        // Random traffic with illegal codes, random acks and rare clears
        for (int i = 0; i < 3000; i++) begin
            logic       v, ak, cl;
            logic [3:0] dg;
            int         r;
            v  = ($urandom_range(0, 9) < 7);
            r  = $urandom_range(0, 19);
            dg = (r < 16) ? 4'(r % 10) : 4'(10 + $urandom_range(0, 5));
            ak = ($urandom_range(0, 9) < 4);
            cl = ($urandom_range(0, 49) == 0);
            step(v, dg, ak, cl);
        end

        // Asynchronous reset after three digits of a fresh frame
        step(1'b0, 4'd0, 1'b0, 1'b1);
        step(1'b1, 4'd2, 1'b0, 1'b0);
        step(1'b1, 4'd5, 1'b0, 1'b0);
        step(1'b1, 4'd8, 1'b0, 1'b0);
        digit_valid = 1'b0;
        frame_ack   = 1'b0;
        clear       = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_digit_cnt", digit_cnt, 0);
        chk("async_a", a, 0);
        chk("async_b", b, 0);
        chk("async_c", c, 0);
        chk("async_frame_valid", frame_valid, 0);
        chk("async_err_digit", err_digit, 0);
`ifdef BCD_FRAME_ALTSUM_EN
        chk("async_altsum", altsum, 0);
`endif
        mcnt = 0;
        md   = '{0, 0, 0, 0};
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 4'd6, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b0);

        chk("frames_outstanding", frame_q.size(), 0);
        chk("errs_outstanding", err_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/bcd_frame_collector.md
Name: bcd_frame_collector

Overview:
- Upstream stage of the div11 divisibility checker.
- Accepts a serial stream of BCD digits, one per handshake, most significant digit first.
- Rejects illegal codes (>9).
- Once four valid digits are assembled, presents them in parallel on a/b/c/d with a frame_valid flag, which the div11 consumer acknowledges.

Parameters:
- NUM_DIGITS, 4: digits per frame. The a/b/c/d port mapping is fixed for 4; other values are unsupported.
- DIGIT_W, 4: bits per BCD digit.
- MAX_DIGIT, 9: largest legal digit code. Codes above this are rejected.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, active-low, asynchronous assert, synchronous deassert at the source.
- clear  input  1  synchronous abort. Discards any partial or held frame.
- digit_in  input  4  BCD digit.
- digit_valid  input  1  digit_in is valid this cycle.
- digit_ready  output  1  collector can accept a digit.
- a  output  4  frame digit 0 (most significant; first received).
- b  output  4  frame digit 1.
- c  output  4  frame digit 2.
- d  output  4  frame digit 3 (least significant; last received).
- frame_valid  output  1  a..d hold a complete frame.
- frame_ack  input  1  consumer has taken the frame.
- err_digit  output  1  one-cycle pulse: an illegal digit was rejected.
- digit_cnt  output  3  digits accepted in the current frame (0..4).

Behaviour:
- Clocking and reset
  - One clock domain; reset is asynchronous and active-low.
  - On rst_n=0: a=b=c=d=0, frame_valid=0, err_digit=0, digit_cnt=0, state=COLLECT, digit_ready=1.
- States: COLLECT, FULL.
  - digit_ready = (state==COLLECT) and not clear.
- Accept rule
  - A digit is accepted when digit_valid and digit_ready are both high and digit_in <= MAX_DIGIT.
  - The digit is written to slot digit_cnt (0→a, 1→b, 2→c, 3→d), and digit_cnt increments on the same edge.
- Frame completion
  - Accepting the 4th digit moves the block to FULL.
  - frame_valid=1 and digit_cnt=4 from the next cycle.
  - Latency: last digit accepted to frame_valid is 1 clock.
- FULL state
  - a..d are stable; frame_valid holds until frame_ack.
  - frame_ack in FULL: go to COLLECT, frame_valid=0 and digit_cnt=0 next cycle.
  - a..d keep their last values until overwritten slot by slot.
  - frame_ack while in COLLECT is ignored.
- Illegal digit (digit_valid, digit_ready, digit_in>9)
  - The digit is dropped; digit_cnt and the slots are unchanged.
  - err_digit=1 for exactly the next cycle.
  - Back-to-back illegal digits give back-to-back pulses.
- digit_valid while digit_ready=0 (FULL): ignored, no err_digit. The source must hold the digit.
- clear
  - Highest priority after reset. Next cycle: state=COLLECT, digit_cnt=0, frame_valid=0.
  - a..d are zeroed; no err_digit is raised.
  - clear together with digit_valid: the digit is not accepted.
  - clear together with frame_ack: clear wins; the result is the same.
- Reset mid-frame: the partial frame is lost and all outputs return to their reset values immediately.
- Width rules: digit_cnt saturates at 4; there is no wrap-around path.

Optional Feature:
- Macro: BCD_FRAME_ALTSUM_EN.
- Defined:
  - Adds output altsum, 4 bits: running alternating digit sum mod 11, with weight +1 for odd positions counted from the least significant digit.
  - Because digits arrive MSD first, the accumulator uses acc_next = (digit − acc) mod 11, range 0..10, updated on each accepted digit.
  - It is valid when frame_valid=1; a value of 0 means the frame is divisible by 11. This is a cross-check for div11.
  - The accumulator clears on reset, clear, and frame_ack.
- Undefined: the port and logic are absent.

Decomposition:
- Shared package bcd_pkg:
  - DIGIT_W and MAX_DIGIT constants.
  - Typedef bcd_digit_t (4-bit).
  - State enum coll_state_t {COLLECT, FULL}.
  - MOD11 constant (11).
- The accumulator is a natural sub-module, bcd_altsum_mod11: clk, rst_n, clr, en, digit, sum. It is instantiated only under BCD_FRAME_ALTSUM_EN.

Test Plan:
- Feed 9,9,9,9, one per cycle → frame_valid=1 the cycle after the 4th; a=b=c=d=9; digit_cnt=4. With the macro, altsum=0.
- Feed 1,2,A,3,4 → err_digit pulses once after A; frame ends with a=1, b=2, c=3, d=4; the 1234 frame gives altsum=2.
- In FULL: hold digit_valid with 5 for 3 cycles, then frame_ack → 5 is not accepted before the ack, frame_valid drops; 5 is accepted into a the cycle after the ack.
- Feed 7,8, then pulse clear simultaneous with digit_valid=6 → digit_cnt=0, a..d=0, 6 is not accepted, no err_digit.
- Assert rst_n=0 asynchronously mid-frame after 3 digits → all outputs are 0 without waiting for a clock edge; digit_ready=1 after release.
- Ack and immediately feed 0,0,0,0 → the second frame is valid 1 cycle after its 4th digit; back-to-back frame throughput is 5 cycles per frame.
